fft8_sched: RTL and testbench

FFT8_SCHED -- requirements
Module: fft8_sched

---
 rtl/fft8_sched.sv | 119 +++++++++++
 tb/tb_fft8_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_sched.sv
// rtl/fft8_sched.sv - address/twiddle scheduler for one 8-point radix-2 DIT FFT pass
// Issues 12 butterflies (3 stages x 4) to a shared butterfly unit and strobes the writeback of each.
module fft8_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       bf_ack,
    output logic       bf_req,
    output logic [2:0] addr_a,
    output logic [2:0] addr_b,
    output logic [1:0] tw_idx,
    output logic       wr_en,
    output logic [1:0] stage,
    output logic [1:0] bf_cnt,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state;
    logic [1:0] stage_q;
    logic [1:0] cnt_q;
    logic       in_pass;
    logic [2:0] a_raw;
    logic [2:0] b_raw;
    logic [1:0] tw_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            stage_q <= 2'd0;
            cnt_q   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ISSUE;
                        stage_q <= 2'd0;
                        cnt_q   <= 2'd0;
                    end
                end
                ISSUE: begin
                    // Abort takes priority over a simultaneous acknowledge.
                    if (abort) begin
                        state   <= IDLE;
                        stage_q <= 2'd0;
                        cnt_q   <= 2'd0;
                    end else if (bf_ack) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state   <= IDLE;
                        stage_q <= 2'd0;
                        cnt_q   <= 2'd0;
                    end else if (cnt_q == 2'd3) begin
                        cnt_q <= 2'd0;
                        if (stage_q == 2'd2) begin
                            state   <= DONE;
                            stage_q <= 2'd0;
                        end else begin
                            state   <= ISSUE;
                            stage_q <= stage_q + 2'd1;
                        end
                    end else begin
                        state <= ISSUE;
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Closed form of a = g*2*half + j, b = a + half, tw = j << (2 - stage).
    always_comb begin
        a_raw  = 3'd0;
        b_raw  = 3'd0;
        tw_raw = 2'd0;
        case (stage_q)
            2'd0: begin
                a_raw  = {cnt_q, 1'b0};
                b_raw  = {cnt_q, 1'b1};
                tw_raw = 2'd0;
            end
            2'd1: begin
                a_raw  = {cnt_q[1], 1'b0, cnt_q[0]};
                b_raw  = {cnt_q[1], 1'b1, cnt_q[0]};
                tw_raw = {cnt_q[0], 1'b0};
            end
            default: begin
                a_raw  = {1'b0, cnt_q};
                b_raw  = {1'b1, cnt_q};
                tw_raw = cnt_q;
            end
        endcase
    end

    // Addresses are zeroed outside an active butterfly so IDLE/reset shows all-zero outputs.
    assign in_pass = (state == ISSUE) || (state == WRITE);
    assign addr_a  = in_pass ? a_raw  : 3'd0;
    assign addr_b  = in_pass ? b_raw  : 3'd0;
    assign tw_idx  = in_pass ? tw_raw : 2'd0;
    assign bf_req  = (state == ISSUE);
    assign wr_en   = (state == WRITE);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign stage   = stage_q;
    assign bf_cnt  = cnt_q;

endmodule

// File: tb/tb_fft8_sched.sv
// tb/tb_fft8_sched.sv - directed self-checking bench for fft8_sched
module tb_fft8_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       bf_ack = 1'b1;
    logic       bf_req;
    logic [2:0] addr_a;
    logic [2:0] addr_b;
    logic [1:0] tw_idx;
    logic       wr_en;
    logic [1:0] stage;
    logic [1:0] bf_cnt;
    logic       busy;
    logic       done;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [2:0] exp_a  [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0] exp_b  [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [1:0] exp_tw [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

    fft8_sched dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .bf_ack(bf_ack),
        .bf_req(bf_req), .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx),
        .wr_en(wr_en), .stage(stage), .bf_cnt(bf_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({bf_req, wr_en, busy, done, addr_a, addr_b, tw_idx, stage, bf_cnt} !== 17'd0)
            $display("FAIL reset_outputs got %b want 0",
                     {bf_req, wr_en, busy, done, addr_a, addr_b, tw_idx, stage, bf_cnt});
        else pass_cnt++;
        tick();
        tick();
        reset = 1'b0;
        tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_full_pass();
        int done_seen;
        bf_ack = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            total_cnt++;
            if (bf_req !== 1'b1 || wr_en !== 1'b0 || addr_a !== exp_a[k] || addr_b !== exp_b[k] || tw_idx !== exp_tw[k])
                $display("FAIL full_issue%0d req=%b wr=%b a=%0d b=%0d tw=%0d want req=1 wr=0 a=%0d b=%0d tw=%0d",
                         k, bf_req, wr_en, addr_a, addr_b, tw_idx, exp_a[k], exp_b[k], exp_tw[k]);
            else pass_cnt++;
            if (done) done_seen++;
            tick();
            total_cnt++;
            if (wr_en !== 1'b1 || bf_req !== 1'b0 || addr_a !== exp_a[k] || addr_b !== exp_b[k])
                $display("FAIL full_write%0d wr=%b req=%b a=%0d b=%0d want wr=1 req=0 a=%0d b=%0d",
                         k, wr_en, bf_req, addr_a, addr_b, exp_a[k], exp_b[k]);
            else pass_cnt++;
            if (done) done_seen++;
            tick();
        end
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b1 || done_seen != 0)
            $display("FAIL full_done25 done=%b busy=%b early=%0d want done=1 busy=1 early=0", done, busy, done_seen);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL full_idle26 busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int cyc;
        bf_ack = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 12; k++) begin
            if (k == 5) begin
                bf_ack = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    total_cnt++;
                    if (bf_req !== 1'b1 || wr_en !== 1'b0 || addr_a !== 3'd1 || addr_b !== 3'd3 || tw_idx !== 2'd2)
                        $display("FAIL stall_hold%0d req=%b wr=%b a=%0d b=%0d tw=%0d want 1 0 1 3 2",
                                 s, bf_req, wr_en, addr_a, addr_b, tw_idx);
                    else pass_cnt++;
                    tick();
                    cyc++;
                end
                bf_ack = 1'b1;
            end
            total_cnt++;
            if (bf_req !== 1'b1 || addr_a !== exp_a[k] || addr_b !== exp_b[k] || tw_idx !== exp_tw[k])
                $display("FAIL stall_issue%0d req=%b a=%0d b=%0d tw=%0d want 1 %0d %0d %0d",
                         k, bf_req, addr_a, addr_b, tw_idx, exp_a[k], exp_b[k], exp_tw[k]);
            else pass_cnt++;
            tick();
            cyc++;
            total_cnt++;
            if (wr_en !== 1'b1 || addr_a !== exp_a[k])
                $display("FAIL stall_write%0d wr=%b a=%0d want 1 %0d", k, wr_en, addr_a, exp_a[k]);
            else pass_cnt++;
            tick();
            cyc++;
        end
        total_cnt++;
        if (done !== 1'b1 || cyc != 28)
            $display("FAIL stall_done done=%b cycle=%0d want 1 28", done, cyc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_abort();
        int done_seen;
        bf_ack = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_seen = 0;
        for (int c = 1; c < 17; c++) begin
            if (done) done_seen++;
            tick();
        end
        total_cnt++;
        if (bf_req !== 1'b1 || stage !== 2'd2 || bf_cnt !== 2'd0 || addr_a !== 3'd0 || addr_b !== 3'd4)
            $display("FAIL abort_pre req=%b stage=%0d cnt=%0d a=%0d b=%0d want 1 2 0 0 4",
                     bf_req, stage, bf_cnt, addr_a, addr_b);
        else pass_cnt++;
        abort = 1'b1;
        bf_ack = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || bf_req !== 1'b0 || stage !== 2'd0 || bf_cnt !== 2'd0)
            $display("FAIL abort_post wr=%b busy=%b req=%b stage=%0d cnt=%0d want all 0",
                     wr_en, busy, bf_req, stage, bf_cnt);
        else pass_cnt++;
        for (int c = 0; c < 6; c++) begin
            if (done || busy) done_seen++;
            tick();
        end
        total_cnt++;
        if (done_seen != 0) $display("FAIL abort_nodone events=%0d want 0", done_seen);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int done_seen;
        bf_ack = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_seen = 0;
        for (int c = 1; c < 36; c++) begin
            start = (c == 5 || c == 25);
            if (done) done_seen++;
            if (c == 25) begin
                total_cnt++;
                if (done !== 1'b1) $display("FAIL ign_done25 done=%b want 1", done);
                else pass_cnt++;
            end
            tick();
        end
        start = 1'b0;
        total_cnt++;
        if (done_seen != 1 || busy !== 1'b0)
            $display("FAIL ign_single done_count=%0d busy=%b want 1 0", done_seen, busy);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int cyc;
        bf_ack = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        total_cnt++;
        if (wr_en !== 1'b1) $display("FAIL areset_pre wr=%b want 1", wr_en);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (wr_en !== 1'b0 || bf_req !== 1'b0 || busy !== 1'b0 || stage !== 2'd0 || bf_cnt !== 2'd0)
            $display("FAIL areset_drop wr=%b req=%b busy=%b stage=%0d cnt=%0d want all 0",
                     wr_en, bf_req, busy, stage, bf_cnt);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL areset_needstart busy=%b want 0", busy);
        else pass_cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if (bf_req !== 1'b1 || stage !== 2'd0 || bf_cnt !== 2'd0 || addr_a !== 3'd0 || addr_b !== 3'd1)
            $display("FAIL areset_restart req=%b stage=%0d cnt=%0d a=%0d b=%0d want 1 0 0 0 1",
                     bf_req, stage, bf_cnt, addr_a, addr_b);
        else pass_cnt++;
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        total_cnt++;
        if (cyc != 25) $display("FAIL areset_done cycle=%0d want 25", cyc);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_stall();
        test_abort();
        test_start_ignored();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
